// File: rtl/hline_burst_master_pkg.sv
// Shared constants, state encoding and small helpers for the hline burst master.
package hline_pkg;

  localparam int BURST_LEN_DEF = 256;
  localparam int ADDR_W_DEF    = 32;
  localparam int DATA_W_DEF    = 32;
  localparam int BEAT_W        = 9;

  localparam logic [1:0] BRESP_OKAY = 2'b00;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_CMD  = 3'd1;
  localparam logic [2:0] ST_RD_DATA = 3'd2;
  localparam logic [2:0] ST_WR_CMD  = 3'd3;
  localparam logic [2:0] ST_WR_DATA = 3'd4;
  localparam logic [2:0] ST_WR_RESP = 3'd5;
  localparam logic [2:0] ST_DONE    = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_RD_CMD  = ST_RD_CMD,
    S_RD_DATA = ST_RD_DATA,
    S_WR_CMD  = ST_WR_CMD,
    S_WR_DATA = ST_WR_DATA,
    S_WR_RESP = ST_WR_RESP,
    S_DONE    = ST_DONE
  } state_e;

  // Bus length field encodes beats-1.
  function automatic logic [7:0] len_field(input int burst_len);
    return 8'(burst_len - 1);
  endfunction

endpackage

// File: rtl/hline_burst_master_if.sv
// AXI-style burst master port: command, read data, write data and write response channels.
interface hline_burst_master_if #(
  parameter int ADDR_W = hline_pkg::ADDR_W_DEF,
  parameter int DATA_W = hline_pkg::DATA_W_DEF
);
  logic                  m_cmd_valid;
  logic                  m_cmd_ready;
  logic                  m_cmd_write;
  logic [ADDR_W-1:0]     m_cmd_addr;
  logic [7:0]            m_cmd_len;
  logic [DATA_W-1:0]     m_rdata;
  logic                  m_rvalid;
  logic                  m_rlast;
  logic                  m_rready;
  logic [DATA_W-1:0]     m_wdata;
  logic [DATA_W/8-1:0]   m_wstrb;
  logic                  m_wvalid;
  logic                  m_wlast;
  logic                  m_wready;
  logic                  m_bvalid;
  logic [1:0]            m_bresp;
  logic                  m_bready;

  modport master (
    output m_cmd_valid, m_cmd_write, m_cmd_addr, m_cmd_len,
    input  m_cmd_ready,
    input  m_rdata, m_rvalid, m_rlast,
    output m_rready,
    output m_wdata, m_wstrb, m_wvalid, m_wlast,
    input  m_wready,
    input  m_bvalid, m_bresp,
    output m_bready
  );

  modport slave (
    input  m_cmd_valid, m_cmd_write, m_cmd_addr, m_cmd_len,
    output m_cmd_ready,
    output m_rdata, m_rvalid, m_rlast,
    input  m_rready,
    input  m_wdata, m_wstrb, m_wvalid, m_wlast,
    output m_wready,
    output m_bvalid, m_bresp,
    input  m_bready
  );
endinterface

// File: rtl/hline_burst_master_beat_ctr.sv
// Beat counter for one burst: cleared at burst start, saturates at the last beat so it never wraps.
module hline_beat_ctr
  import hline_pkg::*;
#(
  parameter int BURST_LEN = BURST_LEN_DEF
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              clr,
  input  logic              en,
  output logic [BEAT_W-1:0] cnt,
  output logic              last
);

  logic [BEAT_W-1:0] cnt_d;
  logic [BEAT_W-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !last) begin
      cnt_d = cnt_q + BEAT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign last = (cnt_q == BEAT_W'(BURST_LEN - 1));

endmodule

// File: rtl/hline_burst_master.sv
// Burst engine behind the hline z-buffer FSM: read bursts fill the z-read FIFO,
// write bursts drain the data/byte-enable FIFOs, one done pulse per burst.
module hline_burst_master
  import hline_pkg::*;
#(
  parameter int BURST_LEN = BURST_LEN_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                nreset,
  input  logic                rd_req,
  input  logic                wr_req,
  input  logic [ADDR_W-1:0]   addr,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [DATA_W-1:0]   zfifo_wdata,
  output logic                zfifo_wr,
  input  logic                zfifo_full,
  input  logic [DATA_W-1:0]   src_rdata,
  input  logic [DATA_W/8-1:0] src_be,
  input  logic                src_empty,
  output logic                src_rd,
  hline_burst_master_if.master m
);

  localparam logic [7:0]        LEN_FIELD = len_field(BURST_LEN);
  localparam logic [ADDR_W-1:0] ADDR_MASK = ~(ADDR_W'(3));

  state_e              state_d, state_q;
  logic [ADDR_W-1:0]   addr_d, addr_q;
  logic                err_d, err_q;
  logic                beat_clr_s;
  logic                beat_en_s;
  logic [BEAT_W-1:0]   beat_cnt_s;
  logic                beat_last_s;

  hline_beat_ctr #(.BURST_LEN(BURST_LEN)) u_beat_ctr (
    .clk    (clk),
    .nreset (nreset),
    .clr    (beat_clr_s),
    .en     (beat_en_s),
    .cnt    (beat_cnt_s),
    .last   (beat_last_s)
  );

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    err_d         = err_q;
    beat_clr_s    = 1'b0;
    beat_en_s     = 1'b0;
    busy          = (state_q != S_IDLE);
    done          = 1'b0;
    err           = err_q;
    zfifo_wdata   = '0;
    zfifo_wr      = 1'b0;
    src_rd        = 1'b0;
    m.m_cmd_valid = 1'b0;
    m.m_cmd_write = 1'b0;
    m.m_cmd_addr  = '0;
    m.m_cmd_len   = 8'h00;
    m.m_rready    = 1'b0;
    m.m_wdata     = '0;
    m.m_wstrb     = '0;
    m.m_wvalid    = 1'b0;
    m.m_wlast     = 1'b0;
    m.m_bready    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Read wins when both requests arrive together.
        if (rd_req || wr_req) begin
          state_d    = rd_req ? S_RD_CMD : S_WR_CMD;
          addr_d     = addr & ADDR_MASK;
          err_d      = 1'b0;
          beat_clr_s = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD_CMD, S_WR_CMD: begin
        m.m_cmd_valid = 1'b1;
        m.m_cmd_write = (state_q == S_WR_CMD);
        m.m_cmd_addr  = addr_q;
        m.m_cmd_len   = LEN_FIELD;
        if (m.m_cmd_ready) begin
          state_d = (state_q == S_WR_CMD) ? S_WR_DATA : S_RD_DATA;
        end else begin
          state_d = state_q;
        end
      end
      S_RD_DATA: begin
        m.m_rready = !zfifo_full;
        if (m.m_rvalid && !zfifo_full) begin
          zfifo_wr    = 1'b1;
          zfifo_wdata = m.m_rdata;
          beat_en_s   = 1'b1;
          // rlast is only checked; the beat count alone ends the burst.
          if (m.m_rlast != beat_last_s) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
          state_d = beat_last_s ? S_DONE : S_RD_DATA;
        end else begin
          state_d = S_RD_DATA;
        end
      end
      S_WR_DATA: begin
        m.m_wvalid = !src_empty;
        if (!src_empty) begin
          m.m_wdata = src_rdata;
          m.m_wstrb = src_be;
          m.m_wlast = beat_last_s;
        end else begin
          m.m_wlast = 1'b0;
        end
        if (!src_empty && m.m_wready) begin
          src_rd    = 1'b1;
          beat_en_s = 1'b1;
          state_d   = beat_last_s ? S_WR_RESP : S_WR_DATA;
        end else begin
          state_d = S_WR_DATA;
        end
      end
      S_WR_RESP: begin
        m.m_bready = 1'b1;
        if (m.m_bvalid) begin
          state_d = S_DONE;
          err_d   = (m.m_bresp != BRESP_OKAY) ? 1'b1 : err_q;
        end else begin
          state_d = S_WR_RESP;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_hline_burst_master.sv
// Scoreboard bench for hline_burst_master: bench-side bus slave and FIFO models, 256-beat bursts.
module tb_hline_burst_master;
  import hline_pkg::*;

  localparam int BL = 256;

  logic        clk = 1'b0;
  logic        nreset;
  logic        rd_req, wr_req;
  logic [31:0] addr;
  logic        busy, done, err;
  logic [31:0] zfifo_wdata;
  logic        zfifo_wr, zfifo_full;
  logic [31:0] src_rdata;
  logic [3:0]  src_be;
  logic        src_empty, src_rd;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] src_q[$];

  always #5 clk = ~clk;

  hline_burst_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  hline_burst_master #(.BURST_LEN(BL), .ADDR_W(32), .DATA_W(32)) dut (
    .clk         (clk),
    .nreset      (nreset),
    .rd_req      (rd_req),
    .wr_req      (wr_req),
    .addr        (addr),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .zfifo_wdata (zfifo_wdata),
    .zfifo_wr    (zfifo_wr),
    .zfifo_full  (zfifo_full),
    .src_rdata   (src_rdata),
    .src_be      (src_be),
    .src_empty   (src_empty),
    .src_rd      (src_rd),
    .m           (bus.master)
  );

  function automatic logic [118:0] outs_vec();
    return {busy, done, err, zfifo_wr, zfifo_wdata, src_rd, bus.m_cmd_valid, bus.m_cmd_write,
            bus.m_cmd_addr, bus.m_cmd_len, bus.m_rready, bus.m_wdata, bus.m_wstrb,
            bus.m_wvalid, bus.m_wlast, bus.m_bready};
  endfunction

  task automatic rd_run(input logic [31:0] a, input bit full_mode, input int extra_rlast,
                        input bit exp_err, input int cmd_wait, input int abort_beat, input bit with_wr);
    int beat, got, last_hs, cyc, b_seen;
    bit pushed, fin;
    logic [31:0] w, e;
    beat = 0; got = 0; last_hs = -10; pushed = 1'b0; fin = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rd_req = 1'b1; addr = a;
    if (with_wr) wr_req = 1'b1;
    #1 n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL rd_idle_busy: got %0b want 0", busy); end
    @(negedge clk);
    rd_req = 1'b0;
    for (int k = 0; k <= cmd_wait; k++) begin
      if (k > 0) @(negedge clk);
      bus.m_cmd_ready = (k == cmd_wait);
      #1 n_cmp++;
      if ({bus.m_cmd_valid, bus.m_cmd_write, bus.m_cmd_addr, bus.m_cmd_len, err} !==
          {1'b1, 1'b0, a & 32'hFFFF_FFFC, 8'(BL - 1), 1'b0}) begin
        n_bad++;
        $display("FAIL rd_cmd: got v=%0b w=%0b a=%h l=%0d err=%0b want v=1 w=0 a=%h l=%0d err=0",
                 bus.m_cmd_valid, bus.m_cmd_write, bus.m_cmd_addr, bus.m_cmd_len, err,
                 a & 32'hFFFF_FFFC, BL - 1);
      end
    end
    for (cyc = 0; cyc < 4000 && !fin; cyc++) begin
      @(negedge clk);
      bus.m_cmd_ready = 1'b0;
      zfifo_full = full_mode && (cyc % 3 != 0);
      if (beat < BL) begin
        if (!pushed) begin
          w = $urandom; exp_q.push_back(w); bus.m_rdata = w; pushed = 1'b1;
        end
        bus.m_rvalid = 1'b1;
        bus.m_rlast  = (beat == BL - 1) || (beat == extra_rlast);
      end else begin
        bus.m_rvalid = 1'b0; bus.m_rlast = 1'b0;
      end
      if (abort_beat >= 0 && beat == abort_beat) begin
        nreset = 1'b0;
        #1 n_cmp++;
        if (outs_vec() !== '0) begin
          n_bad++; $display("FAIL abort_outputs: got %h want 0", outs_vec());
        end
        bus.m_rvalid = 1'b0; bus.m_rlast = 1'b0; zfifo_full = 1'b0;
        exp_q.delete();
        return;
      end
      #1;
      if (zfifo_full) begin
        n_cmp++;
        if ({bus.m_rready, zfifo_wr} !== 2'b00) begin
          n_bad++; $display("FAIL rd_full_stall: got rready=%0b wr=%0b want 0 0", bus.m_rready, zfifo_wr);
        end
      end
      if (zfifo_wr) begin
        n_cmp++;
        b_seen = exp_q.size();
        if (b_seen == 0) begin
          n_bad++; $display("FAIL rd_extra_push: got push %h want none", zfifo_wdata);
        end else begin
          e = exp_q.pop_front();
          if (zfifo_wdata !== e) begin
            n_bad++; $display("FAIL rd_data beat %0d: got %h want %h", got, zfifo_wdata, e);
          end
        end
        got++;
      end
      if (bus.m_rvalid && bus.m_rready) begin
        beat++; pushed = 1'b0; last_hs = cyc;
      end
      if (done) begin
        fin = 1'b1;
        n_cmp++;
        if (got != BL) begin n_bad++; $display("FAIL rd_count: got %0d want %0d", got, BL); end
        n_cmp++;
        if (last_hs != cyc - 1) begin
          n_bad++; $display("FAIL rd_done_timing: got lag %0d want 1", cyc - last_hs);
        end
        n_cmp++;
        if (err !== exp_err) begin n_bad++; $display("FAIL rd_err: got %0b want %0b", err, exp_err); end
      end
    end
    if (!fin) begin
      n_cmp++; n_bad++; $display("FAIL rd_timeout: got no done want done");
    end
    bus.m_rvalid = 1'b0; bus.m_rlast = 1'b0; zfifo_full = 1'b0;
  endtask

  task automatic wr_run(input logic [31:0] a, input bit hold, input bit rnd_ready,
                        input logic [1:0] bresp, input bit exp_err);
    int wbeat, bwait, cyc, b_hs;
    bit fin;
    logic [31:0] w, e;
    src_q.delete(); exp_q.delete();
    for (int i = 0; i < BL; i++) begin
      w = $urandom; src_q.push_back(w); exp_q.push_back(w);
    end
    wbeat = 0; bwait = 0; b_hs = 0; fin = 1'b0;
    @(negedge clk);
    wr_req = 1'b1; addr = a;
    #1 n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL wr_idle_busy: got %0b want 0", busy); end
    @(negedge clk);
    if (!hold) wr_req = 1'b0;
    bus.m_cmd_ready = 1'b1;
    #1 n_cmp++;
    if ({bus.m_cmd_valid, bus.m_cmd_write, bus.m_cmd_addr, bus.m_cmd_len, err} !==
        {1'b1, 1'b1, a & 32'hFFFF_FFFC, 8'(BL - 1), 1'b0}) begin
      n_bad++;
      $display("FAIL wr_cmd: got v=%0b w=%0b a=%h l=%0d err=%0b want v=1 w=1 a=%h l=%0d err=0",
               bus.m_cmd_valid, bus.m_cmd_write, bus.m_cmd_addr, bus.m_cmd_len, err,
               a & 32'hFFFF_FFFC, BL - 1);
    end
    for (cyc = 0; cyc < 4000 && !fin; cyc++) begin
      @(negedge clk);
      bus.m_cmd_ready = 1'b0;
      src_empty = (src_q.size() == 0);
      src_rdata = src_empty ? 32'h0 : src_q[0];
      src_be    = 4'b1010;
      bus.m_wready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.m_bvalid = (bwait >= 2);
      bus.m_bresp  = bresp;
      #1;
      if (bus.m_wvalid && bus.m_wready) begin
        n_cmp++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        if ({bus.m_wdata, bus.m_wstrb, bus.m_wlast, src_rd} !== {e, 4'b1010, (wbeat == BL - 1), 1'b1}) begin
          n_bad++;
          $display("FAIL wr_beat %0d: got d=%h s=%b last=%0b rd=%0b want d=%h s=1010 last=%0b rd=1",
                   wbeat, bus.m_wdata, bus.m_wstrb, bus.m_wlast, src_rd, e, (wbeat == BL - 1));
        end
        if (src_q.size() != 0) void'(src_q.pop_front());
        wbeat++;
      end
      if (bus.m_bready) begin
        if (bus.m_bvalid) begin bwait = 0; b_hs++; end
        else bwait++;
      end
      if (done) begin
        fin = 1'b1;
        n_cmp++;
        if (wbeat != BL || b_hs != 1) begin
          n_bad++; $display("FAIL wr_count: got beats=%0d bresp_hs=%0d want %0d 1", wbeat, b_hs, BL);
        end
        n_cmp++;
        if (err !== exp_err) begin n_bad++; $display("FAIL wr_err: got %0b want %0b", err, exp_err); end
      end
    end
    if (!fin) begin
      n_cmp++; n_bad++; $display("FAIL wr_timeout: got no done want done");
    end
    bus.m_wready = 1'b0; bus.m_bvalid = 1'b0; bus.m_bresp = 2'b00; src_empty = 1'b1;
  endtask

  task automatic test_reset();
    nreset = 1'b0; rd_req = 1'b0; wr_req = 1'b0; addr = 32'h0;
    zfifo_full = 1'b0; src_rdata = 32'h0; src_be = 4'h0; src_empty = 1'b1;
    bus.m_cmd_ready = 1'b0; bus.m_rdata = 32'h0; bus.m_rvalid = 1'b0; bus.m_rlast = 1'b0;
    bus.m_wready = 1'b0; bus.m_bvalid = 1'b0; bus.m_bresp = 2'b00;
    repeat (3) @(negedge clk);
    #1 n_cmp++;
    if (outs_vec() !== '0) begin n_bad++; $display("FAIL reset_outputs: got %h want 0", outs_vec()); end
    nreset = 1'b1;
  endtask

  task automatic test_read_basic();
    rd_run(32'h1000_0003, 1'b0, -1, 1'b0, 0, -1, 1'b0);
    @(negedge clk);
    #1 n_cmp++;
    if ({busy, done} !== 2'b00) begin n_bad++; $display("FAIL rd_after_done: got busy=%0b done=%0b want 0 0", busy, done); end
  endtask

  task automatic test_read_backpressure();
    rd_run(32'h1000_0400, 1'b1, -1, 1'b0, 3, -1, 1'b0);
  endtask

  task automatic test_write_back_to_back();
    wr_run(32'h1000_0040, 1'b1, 1'b1, 2'b00, 1'b0);
    wr_run(32'h2000_0000, 1'b0, 1'b1, 2'b00, 1'b0);
  endtask

  task automatic test_rd_wr_same_cycle();
    rd_run(32'h3000_0000, 1'b0, -1, 1'b0, 0, -1, 1'b1);
    wr_run(32'h3000_1000, 1'b0, 1'b0, 2'b00, 1'b0);
  endtask

  task automatic test_errors();
    wr_run(32'h4000_0000, 1'b0, 1'b0, 2'b10, 1'b1);
    @(negedge clk);
    #1 n_cmp++;
    if ({busy, err} !== 2'b01) begin n_bad++; $display("FAIL err_sticky: got busy=%0b err=%0b want 0 1", busy, err); end
    rd_run(32'h4000_1000, 1'b0, 10, 1'b1, 0, -1, 1'b0);
  endtask

  task automatic test_reset_mid_burst();
    rd_run(32'h5000_0000, 1'b0, -1, 1'b0, 0, 100, 1'b0);
    @(negedge clk);
    nreset = 1'b1;
    rd_run(32'h5000_0800, 1'b0, -1, 1'b0, 0, -1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_read_backpressure();
    test_write_back_to_back();
    test_rd_wr_same_cycle();
    test_errors();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
